// File: rtl/filter_config_sequencer_pkg.sv
// Shared definitions for the filter configuration sequencer.
//   - seq_state_e : 2-bit FSM state encoding, also exposed on the debug port
//   - ADDR_*      : register-interface byte addresses
//   - *_W         : configuration bus and counter widths
package filter_config_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_QUIET = 2'd1,
        APPLY      = 2'd2,
        SETTLE     = 2'd3
    } seq_state_e;

    localparam logic [1:0] ADDR_SIG = 2'd0;  // signal_config
    localparam logic [1:0] ADDR_FLO = 2'd1;  // filter_config[7:0]
    localparam logic [1:0] ADDR_FHI = 2'd2;  // filter_config[15:8]

    localparam int SIG_CFG_W  = 8;
    localparam int FILT_CFG_W = 16;
    localparam int CNT_W      = 8;   // quiet and settle counters (1..255)
    localparam int WAIT_CNT_W = 10;  // timeout counter (up to 1023)

endpackage

// File: rtl/filter_config_sequencer_quiet_detector.sv
// Counts consecutive cycles in which both signal lines are low.
//   CLK, RESET : clock, asynchronous active-high reset
//   clear      : hold the count at zero (asserted whenever the owner is not waiting)
//   SIGNAL1/2  : monitored signal lines
//   quiet      : high in the cycle that completes QUIET_CYCLES consecutive quiet
//                cycles, i.e. quiet_cnt (including this cycle) >= QUIET_CYCLES
module quiet_detector
    import filter_config_sequencer_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic SIGNAL1,
    input  logic SIGNAL2,
    output logic quiet
);

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    logic [CNT_W-1:0] quiet_cnt;
    logic             both_low;

    assign both_low = !SIGNAL1 && !SIGNAL2;

    // The owner leaves the waiting state as soon as quiet fires, so the
    // count never runs past QUIET_CYCLES and cannot wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            quiet_cnt <= '0;
        end else if (clear || !both_low) begin
            quiet_cnt <= '0;
        end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

    // Counting the current cycle combinationally lets the apply follow the
    // last quiet cycle directly instead of one cycle later.
    assign quiet = both_low && (quiet_cnt >= QUIET_LAST);

endmodule

// File: rtl/filter_config_sequencer.sv
// Sequences configuration of the signal-input and staged-filter stages.
// Byte writes land in shadow registers; a commit waits for both signal lines
// to be quiet (or for a timeout), copies the shadows to the live buses, holds
// read_mode for a settle window and then pulses cfg_done.
//   wr_valid/wr_ready/wr_addr/wr_data : shadow write port (accepted in IDLE only)
//   commit                            : start an apply sequence (IDLE only)
//   SIGNAL1/SIGNAL2                   : lines that must be quiet before apply
//   signal_config/filter_config       : live configuration buses
//   read_mode, busy                   : high whenever the FSM is not IDLE
//   cfg_done                          : one-cycle pulse on the first IDLE cycle
//   addr_err, timeout                 : sticky flags, cleared by an accepted commit
//   state_dbg                         : current FSM state
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
// wr_ready is a pure function of state and never depends on wr_valid.
module filter_config_sequencer
    import filter_config_sequencer_pkg::*;
#(
    parameter int unsigned              QUIET_CYCLES   = 8,
    parameter int unsigned              SETTLE_CYCLES  = 16,
    parameter int unsigned              TIMEOUT_CYCLES = 1023,
    parameter logic [SIG_CFG_W-1:0]     SIG_CFG_RESET  = 8'hC3,
    parameter logic [FILT_CFG_W-1:0]    FILT_CFG_RESET = 16'h0000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  commit,
    input  logic                  SIGNAL1,
    input  logic                  SIGNAL2,
    output logic [SIG_CFG_W-1:0]  signal_config,
    output logic [FILT_CFG_W-1:0] filter_config,
    output logic                  read_mode,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  addr_err,
    output logic                  timeout,
    output seq_state_e            state_dbg
);

    localparam logic [CNT_W-1:0]      SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e             state, state_next;
    logic [SIG_CFG_W-1:0]   sig_shadow;
    logic [FILT_CFG_W-1:0]  filt_shadow;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   quiet;
    logic                   wait_expired;
    logic                   settle_done;
    logic                   wr_fire;
    logic                   commit_fire;

    quiet_detector #(.QUIET_CYCLES(QUIET_CYCLES)) u_quiet (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (state != WAIT_QUIET),
        .SIGNAL1 (SIGNAL1),
        .SIGNAL2 (SIGNAL2),
        .quiet   (quiet)
    );

    assign wr_ready     = (state == IDLE);
    assign wr_fire      = wr_valid && wr_ready;
    assign commit_fire  = commit && (state == IDLE);
    assign wait_expired = (wait_cnt == TIMEOUT_LAST);
    assign settle_done  = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    // Decoded straight from state so reset drops them without waiting for a clock.
    assign read_mode    = (state != IDLE);
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (commit) state_next = WAIT_QUIET;
            WAIT_QUIET: if (quiet || wait_expired) state_next = APPLY;
            APPLY:      state_next = SETTLE;
            SETTLE:     if (settle_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Counters are held at zero outside their own state, so each starts at 0
    // on entry.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt   <= '0;
            settle_cnt <= '0;
            cfg_done   <= 1'b0;
        end else begin
            wait_cnt   <= (state == WAIT_QUIET) ? wait_cnt + 1'b1 : '0;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            cfg_done   <= settle_done;
        end
    end

    // Shadows and addr_err. A write and a commit in the same cycle both take
    // effect: the write lands at this edge and the apply happens later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sig_shadow  <= SIG_CFG_RESET;
            filt_shadow <= FILT_CFG_RESET;
            addr_err    <= 1'b0;
        end else begin
            if (wr_fire) begin
                case (wr_addr)
                    ADDR_SIG: sig_shadow        <= wr_data;
                    ADDR_FLO: filt_shadow[7:0]  <= wr_data;
                    ADDR_FHI: filt_shadow[15:8] <= wr_data;
                    default:  addr_err          <= 1'b1;
                endcase
            end
            if (commit_fire) addr_err <= 1'b0;
        end
    end

    // timeout is only set when the wait expired without quiet in the same cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timeout <= 1'b0;
        end else if (commit_fire) begin
            timeout <= 1'b0;
        end else if ((state == WAIT_QUIET) && wait_expired && !quiet) begin
            timeout <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            signal_config <= SIG_CFG_RESET;
            filter_config <= FILT_CFG_RESET;
        end else if (state == APPLY) begin
            signal_config <= sig_shadow;
            filter_config <= filt_shadow;
        end
    end

endmodule
